// File: rtl/motor_ctl_pkg.sv
// ============================================================================
// motor_ctl_pkg : shared types, default sizes and the motor_ctl packing helper
// Revision      : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package motor_ctl_pkg;

  localparam int C_NUM_MOTORS = 6;
  localparam int C_DUTY_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_DEAD  = 3'd2,
    ST_APPLY = 3'd3,
    ST_RAMP  = 3'd4
  } state_t;

  // Bit 2i+1 carries the direction of motor i, bit 2i its on/off flag.
  function automatic logic [2*C_NUM_MOTORS-1:0] interleave_ctl(
    input logic [C_NUM_MOTORS-1:0] dir,
    input logic [C_NUM_MOTORS-1:0] en
  );
    logic [2*C_NUM_MOTORS-1:0] w_word;
    w_word = '0;
    for (int i = 0; i < C_NUM_MOTORS; i++) begin
      w_word[2*i+1] = dir[i];
      w_word[2*i]   = en[i];
    end
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler : free-running divider, one-cycle tick every TICK_DIV clocks
// Revision       : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
// ============================================================================
// motor_cmd_sequencer : one-at-a-time motor command sequencer with soft duty
//                       ramping, drain-to-zero and dead time on reversal
// Revision            : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module motor_cmd_sequencer
  import motor_ctl_pkg::*;
#(
  parameter int NUM_MOTORS = C_NUM_MOTORS,
  parameter int DUTY_W     = C_DUTY_W,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [NUM_MOTORS-1:0]   cmd_dir,
  input  logic [NUM_MOTORS-1:0]   cmd_en,
  input  logic [DUTY_W-1:0]       cmd_duty,
  output logic [2*NUM_MOTORS-1:0] motor_ctl,
  output logic [DUTY_W-1:0]       duty_cycle,
  output logic                    busy
);

  localparam int            DW        = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);

  state_t                  r_state;
  logic [2*NUM_MOTORS-1:0] r_ctl;
  logic [DUTY_W-1:0]       r_duty;
  logic [NUM_MOTORS-1:0]   r_tgt_dir;
  logic [NUM_MOTORS-1:0]   r_tgt_en;
  logic [DUTY_W-1:0]       r_tgt_duty;
  logic [NUM_MOTORS-1:0]   r_rev;
  logic [DW-1:0]           r_dead;

  logic                    w_tick;
  logic [NUM_MOTORS-1:0]   w_cur_on;
  logic [NUM_MOTORS-1:0]   w_cur_dir;
  logic [NUM_MOTORS-1:0]   w_rev;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_split
    assign w_cur_on[i]  = r_ctl[2*i];
    assign w_cur_dir[i] = r_ctl[2*i+1];
  end

  // A reversal only matters for a motor that is running now and stays on.
  assign w_rev = w_cur_on & cmd_en & (w_cur_dir ^ cmd_dir);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ctl      <= '0;
      r_duty     <= '0;
      r_tgt_dir  <= '0;
      r_tgt_en   <= '0;
      r_tgt_duty <= '0;
      r_rev      <= '0;
      r_dead     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_tgt_dir  <= cmd_dir;
            r_tgt_en   <= cmd_en;
            r_tgt_duty <= cmd_duty;
            r_rev      <= w_rev;
            if (w_rev == '0) begin
              r_state <= ST_APPLY;
            end else if (r_duty != '0) begin
              r_state <= ST_DRAIN;
            end else begin
              // Already at zero duty: reversing motors go off for the dead time now.
              r_state <= ST_DEAD;
              r_ctl   <= r_ctl & ~interleave_ctl('0, w_rev);
            end
          end
        end
        ST_DRAIN: begin
          if (w_tick) begin
            r_duty <= r_duty - 1'b1;
            if (r_duty == DUTY_W'(1)) begin
              r_state <= ST_DEAD;
              r_ctl   <= r_ctl & ~interleave_ctl('0, r_rev);
            end
          end
        end
        ST_DEAD: begin
          if (DEAD_TICKS == 0) begin
            r_state <= ST_APPLY;
          end else if (w_tick) begin
            if (r_dead == DEAD_LAST) begin
              r_dead  <= '0;
              r_state <= ST_APPLY;
            end else begin
              r_dead <= r_dead + 1'b1;
            end
          end
        end
        ST_APPLY: begin
          r_ctl   <= interleave_ctl(r_tgt_dir, r_tgt_en);
          r_state <= ST_RAMP;
        end
        ST_RAMP: begin
          if (r_duty == r_tgt_duty) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_duty <= (r_duty < r_tgt_duty) ? r_duty + 1'b1 : r_duty - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign motor_ctl  = r_ctl;
  assign duty_cycle = r_duty;

endmodule

`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
// ============================================================================
// tb_motor_cmd_sequencer : randomized bench against a timeline reference model
// Revision               : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_motor_cmd_sequencer;

  localparam int TD = 4;
  localparam int DT = 2;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_dir;
  logic [5:0]  cmd_en;
  logic [4:0]  cmd_duty;
  logic [11:0] motor_ctl;
  logic [4:0]  duty_cycle;
  logic        busy;

  logic        b_valid;
  logic        b_ready;
  logic [5:0]  b_dir;
  logic [5:0]  b_en;
  logic [4:0]  b_duty;
  logic [11:0] b_ctl;
  logic [4:0]  b_duty_o;
  logic        b_busy;

  int n_checks;
  int n_errors;

  motor_cmd_sequencer #(
    .NUM_MOTORS (6), .DUTY_W (5), .TICK_DIV (TD), .DEAD_TICKS (DT)
  ) dut (
    .clk (clk), .reset_n (reset_n), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_dir (cmd_dir), .cmd_en (cmd_en), .cmd_duty (cmd_duty),
    .motor_ctl (motor_ctl), .duty_cycle (duty_cycle), .busy (busy)
  );

  motor_cmd_sequencer #(
    .NUM_MOTORS (6), .DUTY_W (5), .TICK_DIV (TD), .DEAD_TICKS (0)
  ) dut_nodead (
    .clk (clk), .reset_n (reset_n), .cmd_valid (b_valid), .cmd_ready (b_ready),
    .cmd_dir (b_dir), .cmd_en (b_en), .cmd_duty (b_duty),
    .motor_ctl (b_ctl), .duty_cycle (b_duty_o), .busy (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command becomes a timeline of edge numbers
  // (counted from reset release) at which the outputs are expected to change.
  typedef struct { int at; logic [4:0] v; } dstep_t;

  int          e;
  logic [11:0] m_ctl;
  logic [4:0]  m_duty;
  bit          m_idle;
  int          m_clear_at, m_apply_at, m_idle_at;
  logic [11:0] m_clear_mask, m_apply_val;
  dstep_t      m_dq[$];

  function automatic logic [11:0] mk_ctl(input logic [5:0] dir, input logic [5:0] en);
    logic [11:0] w;
    for (int i = 0; i < 6; i++) begin
      w[2*i+1] = dir[i];
      w[2*i]   = en[i];
    end
    return w;
  endfunction

  // First tick edge strictly after edge n; ticks land on edges TD, 2*TD, ...
  function automatic int next_tick(input int n);
    return (n / TD + 1) * TD;
  endfunction

  task automatic model_reset();
    e = 0; m_ctl = '0; m_duty = '0; m_idle = 1'b1;
    m_clear_at = -1; m_apply_at = -1; m_idle_at = -1;
    m_dq.delete();
  endtask

  task automatic model_accept(input int e0, input logic [5:0] dir, input logic [5:0] en,
                              input logic [4:0] duty);
    logic [5:0] rev, on, cdir;
    int n, v;
    for (int i = 0; i < 6; i++) begin
      on[i]   = m_ctl[2*i];
      cdir[i] = m_ctl[2*i+1];
    end
    rev = on & en & (cdir ^ dir);
    m_idle = 1'b0; m_dq.delete(); m_clear_at = -1;
    n = e0; v = int'(m_duty);
    if (rev != 0) begin
      while (v > 0) begin
        n = next_tick(n); v--;
        m_dq.push_back('{n, 5'(v)});
      end
      m_clear_at = n; m_clear_mask = mk_ctl(6'h00, rev);
      if (DT == 0) n = n + 1;
      else for (int k = 0; k < DT; k++) n = next_tick(n);
      n = n + 1;
    end else begin
      n = e0 + 1;
    end
    m_apply_at = n; m_apply_val = mk_ctl(dir, en);
    while (v != int'(duty)) begin
      n = next_tick(n);
      v = (v < int'(duty)) ? v + 1 : v - 1;
      m_dq.push_back('{n, 5'(v)});
    end
    m_idle_at = n + 1;
  endtask

  // One clock: sample inputs, take the edge, advance the model, compare outputs.
  task automatic step();
    logic       v;
    logic [5:0] d, en;
    logic [4:0] du;
    v = cmd_valid; d = cmd_dir; en = cmd_en; du = cmd_duty;
    @(posedge clk);
    e++;
    if (m_idle && v) model_accept(e, d, en, du);
    if (e == m_clear_at) m_ctl = m_ctl & ~m_clear_mask;
    if (e == m_apply_at) m_ctl = m_apply_val;
    while (m_dq.size() > 0 && m_dq[0].at == e) m_duty = m_dq.pop_front().v;
    if (!m_idle && e == m_idle_at) m_idle = 1'b1;
    #1;
    check_eq("motor_ctl", 32'(motor_ctl), 32'(m_ctl));
    check_eq("duty_cycle", 32'(duty_cycle), 32'(m_duty));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(m_idle));
    check_eq("busy", 32'(busy), 32'(!m_idle));
  endtask

  task automatic send(input logic [5:0] d, input logic [5:0] en, input logic [4:0] du);
    cmd_valid = 1'b1; cmd_dir = d; cmd_en = en; cmd_duty = du;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while (!m_idle && k < max_cycles) begin
      step(); k++;
    end
    if (!m_idle) check_eq("idle_timeout", 32'(k), 32'(0));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    check_eq("rst_ctl", 32'(motor_ctl), 32'h0);
    check_eq("rst_duty", 32'(duty_cycle), 32'h0);
    check_eq("rst_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int k;
    n_checks = 0; n_errors = 0;
    cmd_valid = 1'b0; cmd_dir = '0; cmd_en = '0; cmd_duty = '0;
    b_valid = 1'b0; b_dir = '0; b_en = '0; b_duty = '0;
    model_reset();
    apply_reset();

    // Zero-dead-time instance: reversal at duty 0.
    b_valid = 1'b1; b_dir = 6'h00; b_en = 6'h01; b_duty = 5'd0;
    step();
    b_valid = 1'b0;
    step(); step();
    check_eq("nd_first_ctl", 32'(b_ctl), 32'h001);
    check_eq("nd_first_ready", 32'(b_ready), 32'h1);
    b_valid = 1'b1; b_dir = 6'h01; b_en = 6'h01;
    step();
    b_valid = 1'b0;
    check_eq("nd_e0_ctl", 32'(b_ctl), 32'h000);
    check_eq("nd_e0_busy", 32'(b_busy), 32'h1);
    step();
    check_eq("nd_e1_ctl", 32'(b_ctl), 32'h000);
    step();
    check_eq("nd_e2_ctl", 32'(b_ctl), 32'h003);
    step();
    check_eq("nd_e3_ready", 32'(b_ready), 32'h1);

    // All motors on, ramp to 10.
    send(6'h00, 6'h3F, 5'd10);
    step();
    check_eq("apply_555", 32'(motor_ctl), 32'h555);
    wait_idle(400);
    check_eq("ramp_top", 32'(duty_cycle), 32'd10);

    // Reverse motor 2: drain, dead time, re-ramp.
    send(6'h04, 6'h3F, 5'd10);
    wait_idle(400);
    check_eq("rev_ctl", 32'(motor_ctl), 32'h575);

    // Motor 0 off and duty 10 -> 3: no drain or dead time.
    send(6'h04, 6'h3E, 5'd3);
    step();
    check_eq("m0_off", 32'(motor_ctl[0]), 32'h0);
    wait_idle(400);

    // Valid held high with changing data across several commands.
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cmd_dir = 6'($urandom); cmd_en = 6'($urandom); cmd_duty = 5'($urandom_range(0, 12));
      step();
    end
    cmd_valid = 1'b0;
    wait_idle(800);

    // Reset in the middle of a ramp once duty reaches 7.
    apply_reset();
    send(6'h00, 6'h3F, 5'd20);
    k = 0;
    while (!(m_duty == 5'd7 && e > m_apply_at) && k < 200) begin
      step(); k++;
    end
    check_eq("ramp_at_7", 32'(duty_cycle), 32'd7);
    apply_reset();

    // Random command traffic.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_dir   = 6'($urandom);
      cmd_en    = 6'($urandom);
      cmd_duty  = 5'($urandom);
      step();
    end
    cmd_valid = 1'b0;
    wait_idle(1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_cmd_sequencer.md
# motor_cmd_sequencer

Command sequencer that sits between the CPU-facing command path and the six motor PWM channels, producing the 12-bit per-motor direction/on word and the shared 5-bit duty cycle. It ramps duty changes one step per prescaled tick (soft start/stop). On any motor reversal it drains duty to zero and enforces an off dead time before the new direction is applied. One command is in flight at a time; new commands are back-pressured with a ready/valid handshake.

## Interface
- NUM_MOTORS, 6, number of motor channels
- DUTY_W, 5, duty-cycle width (unsigned)
- TICK_DIV, 50000, clk cycles per ramp/dead-time tick (>= 1)
- DEAD_TICKS, 4, off ticks enforced on reversal (0 allowed)
- clk  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_dir  in  NUM_MOTORS  target direction per motor
- cmd_en  in  NUM_MOTORS  target on/off per motor
- cmd_duty  in  DUTY_W  target shared duty cycle
- motor_ctl  out  2*NUM_MOTORS  bit 2i+1 = dir of motor i, bit 2i = on of motor i
- duty_cycle  out  DUTY_W  current shared duty cycle
- busy  out  1  high whenever state != IDLE

## Operation
- Reset: motor_ctl = 0, duty_cycle = 0, cmd_ready = 1, busy = 0, state IDLE, tick counter 0, dead counter 0.
- Tick: free-running prescaler counts 0..TICK_DIV-1; tick pulses for one cycle on wrap. It is not restarted by commands.
- Accept on clk edge with cmd_valid & cmd_ready; latch tgt_dir, tgt_en, tgt_duty. Compute rev = cur_on & tgt_en & (cur_dir ^ tgt_dir).
- Next state after accept: rev != 0 and duty_cycle != 0 -> DRAIN; rev != 0 and duty_cycle == 0 -> DEAD; rev == 0 -> APPLY.
- DRAIN: on each tick, duty_cycle decrements by 1. When duty_cycle reaches 0, go to DEAD and clear the on-bits of all rev motors in the same edge.
- DEAD: counts DEAD_TICKS ticks. Go to APPLY on the edge of the DEAD_TICKS-th tick. With DEAD_TICKS = 0, DEAD lasts exactly one cycle.
- APPLY: one cycle; motor_ctl <= {tgt_dir, tgt_en} interleaved; go to RAMP.
- RAMP: if duty_cycle == tgt_duty, go to IDLE (no tick wait). Otherwise, on each tick, step duty_cycle by exactly 1 toward tgt_duty.
- Motors that are only turned off, or only change direction while off, need no drain or dead time; they update at APPLY.
- Duty arithmetic is unsigned DUTY_W bits; stepping never over- or undershoots the target and never wraps.
- cmd_valid outside IDLE is ignored (not latched). Command inputs are sampled only at accept.
- Reset asserted mid-sequence returns immediately to reset values (motors off), regardless of state.

## Timing
- No reversal, duty already at target: accept at edge E0; motor_ctl updates at E1 (APPLY); IDLE and cmd_ready at E2.
- Ramp of k steps: k ticks after entering RAMP, then IDLE on the next edge.
- Reversal from duty d: d ticks DRAIN + DEAD_TICKS ticks DEAD + 1 cycle APPLY + ramp.
- All outputs are registered; no combinational path from cmd_* to any output except cmd_ready, which is a pure state decode.

## Structure
- Shared package motor_ctl_pkg: state enum (IDLE, DRAIN, DEAD, APPLY, RAMP), NUM_MOTORS and DUTY_W defaults, and a helper to interleave dir/en into the motor_ctl word.
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, reset_n, tick). The FSM, latches and counters stay in this module.

## Test plan
Bench parameters: TICK_DIV = 4, DEAD_TICKS = 2.
- Reset mid-RAMP (duty 7) -> next cycle motor_ctl = 0, duty_cycle = 0, cmd_ready = 1.
- From reset, cmd en = 6'h3F, dir = 0, duty = 10 -> motor_ctl = 12'h555 one cycle after accept; duty_cycle climbs 1 per 4 clks to 10; then cmd_ready rises.
- At duty 10, all on, cmd dir[2] flips -> duty falls to 0 over 10 ticks; motor_ctl bit4 = 0 for exactly 2 ticks; then bit5 = 1, bit4 = 1; duty ramps back to 10.
- cmd turning motor 0 off and duty 10 -> 3 -> no drain or dead; motor_ctl bit0 = 0 at APPLY; duty steps down 7 ticks.
- cmd_valid held high while busy, with changing data -> no latch, cmd_ready = 0; only the value present at the IDLE edge is taken.
- DEAD_TICKS = 0 variant, reversal at duty 0 -> DEAD lasts 1 cycle, then APPLY; total accept-to-new-dir = 3 edges.
